// File: rtl/fmap_pkg.sv
// Shared types and sizing helpers for the flatten buffer: per-bank occupancy
// state, read-side FSM states and the flattened frame length.
package fmap_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_FETCH  = 2'd1,
    R_STREAM = 2'd2
  } rd_state_e;

  // Number of elements in one flattened frame.
  function automatic int flat_len(input int fw, input int fh, input int fd);
    return fw * fh * fd;
  endfunction

  // $clog2 that never returns zero, so single-entry counters keep a 1-bit width.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_bank_ram.sv
// One bank of pixel storage: simple dual-port RAM, one write port and one
// read port, read data registered. The read register clears on reset so the
// flattened data output reads zero until the first fetch.
module fmap_bank_ram #(
  parameter int DEPTH = 65,
  parameter int AW    = 7,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Storage write; contents are not reset, frames are tracked by beat count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; data holds while rd_en is low so the consumer can stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fmap_flatten_buffer.sv
// Ping-pong capture buffer between the conv stage and the dense stage.
// Pixels (all channels at once) are written by address into the write bank;
// a full bank is streamed out one element per cycle in HWC order.
//
// Read FSM states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   R_IDLE   | waiting for the read bank to become FULL
//   R_FETCH  | RAM read of pixel 0 in flight, output not yet valid
//   R_STREAM | presenting elements; next pixel read issued on the last
//            | channel handshake so the stream never bubbles mid-frame
module fmap_flatten_buffer
  import fmap_pkg::*;
#(
  parameter int F_W        = 13,
  parameter int F_H        = 5,
  parameter int F_D        = 2,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 12,
  parameter int OUT_ADDR_W = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         fm_valid_i,
  input  logic [F_D-1:0][DATA_W-1:0]   fm_data_i,
  input  logic [ADDR_W-1:0]            fm_addr_i,
  output logic                         fm_ready_o,
  output logic                         flat_valid_o,
  output logic [DATA_W-1:0]            flat_data_o,
  output logic [OUT_ADDR_W-1:0]        flat_addr_o,
  output logic                         flat_last_o,
  input  logic                         flat_ready_i,
  output logic                         err_o
);

  localparam int NPIX   = F_W * F_H;
  localparam int LEN    = flat_len(F_W, F_H, F_D);
  localparam int PIX_W  = clog2_min1(NPIX);
  localparam int CH_W   = clog2_min1(F_D);
  localparam int WORD_W = F_D * DATA_W;

  bank_state_e bank_st [2];
  rd_state_e   rd_st;

  logic             wr_bank;
  logic [PIX_W-1:0] wr_cnt;
  logic             rd_bank;
  logic [PIX_W-1:0] rd_pix;
  logic [CH_W-1:0]  rd_ch;

  logic             accept;
  logic             addr_ok;
  logic             wr_en;
  logic             frame_done;
  logic [PIX_W-1:0] wr_addr;

  logic             hs;
  logic             last_hs;
  logic             pix_end;
  logic             rd_en;
  logic [PIX_W-1:0] rd_addr;

  logic [WORD_W-1:0]          bank_q [2];
  logic [F_D-1:0][DATA_W-1:0] rd_word;

  // Write side: a bank is writable while EMPTY or part-way FILLING.
  assign fm_ready_o = (bank_st[wr_bank] == EMPTY) || (bank_st[wr_bank] == FILLING);
  assign accept     = fm_valid_i & fm_ready_o;
  assign addr_ok    = fm_addr_i < ADDR_W'(NPIX);
  assign wr_en      = accept & addr_ok & ~rst_i;
  assign frame_done = wr_en && (wr_cnt == PIX_W'(NPIX - 1));
  assign wr_addr    = fm_addr_i[PIX_W-1:0];

  // Read side: a new pixel is fetched on entry and after each pixel's final
  // channel is handshaked, except after the frame's final element.
  assign hs      = flat_valid_o & flat_ready_i;
  assign last_hs = hs & flat_last_o;
  assign pix_end = hs && (rd_ch == CH_W'(F_D - 1));
  assign rd_en   = ~rst_i & ((rd_st == R_FETCH) |
                             ((rd_st == R_STREAM) & pix_end & ~flat_last_o));
  assign rd_addr = (rd_st == R_FETCH) ? '0 : rd_pix + PIX_W'(1);

  assign rd_word     = bank_q[rd_bank];
  assign flat_data_o = rd_word[rd_ch];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank_ram #(
      .DEPTH (NPIX),
      .AW    (PIX_W),
      .DW    (WORD_W)
    ) u_ram (
      .clk     (clk_i),
      .rst     (rst_i),
      .wr_en   (wr_en && (wr_bank == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (fm_data_i),
      .rd_en   (rd_en && (rd_bank == 1'(b))),
      .rd_addr (rd_addr),
      .rd_data (bank_q[b])
    );
  end

  // Bank occupancy and write bookkeeping. The writer only touches banks in
  // EMPTY/FILLING and the reader only banks in FULL/DRAINING, so both may act
  // in the same cycle without colliding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      wr_cnt     <= '0;
      err_o      <= 1'b0;
    end else begin
      if (accept && !addr_ok) begin
        err_o <= 1'b1;
      end
      if (wr_en) begin
        if (frame_done) begin
          bank_st[wr_bank] <= FULL;
          wr_cnt           <= '0;
          wr_bank          <= ~wr_bank;
        end else begin
          bank_st[wr_bank] <= FILLING;
          wr_cnt           <= wr_cnt + PIX_W'(1);
        end
      end
      if ((rd_st == R_IDLE) && (bank_st[rd_bank] == FULL)) begin
        bank_st[rd_bank] <= DRAINING;
      end
      if (last_hs) begin
        bank_st[rd_bank] <= EMPTY;
        if (bank_st[!rd_bank] == FULL) begin
          bank_st[!rd_bank] <= DRAINING;
        end
      end
    end
  end

  // Read FSM and registered stream outputs (valid, index, last).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_st        <= R_IDLE;
      rd_bank      <= 1'b0;
      rd_pix       <= '0;
      rd_ch        <= '0;
      flat_valid_o <= 1'b0;
      flat_addr_o  <= '0;
      flat_last_o  <= 1'b0;
    end else begin
      case (rd_st)
        R_IDLE: begin
          if (bank_st[rd_bank] == FULL) begin
            rd_st <= R_FETCH;
          end
        end
        R_FETCH: begin
          rd_st        <= R_STREAM;
          flat_valid_o <= 1'b1;
          flat_addr_o  <= '0;
          flat_last_o  <= (LEN == 1);
          rd_pix       <= '0;
          rd_ch        <= '0;
        end
        R_STREAM: begin
          if (hs) begin
            if (flat_last_o) begin
              flat_valid_o <= 1'b0;
              flat_last_o  <= 1'b0;
              flat_addr_o  <= '0;
              rd_bank      <= ~rd_bank;
              rd_st        <= (bank_st[!rd_bank] == FULL) ? R_FETCH : R_IDLE;
            end else begin
              flat_addr_o <= flat_addr_o + OUT_ADDR_W'(1);
              flat_last_o <= (flat_addr_o == OUT_ADDR_W'(LEN - 2));
              if (pix_end) begin
                rd_ch  <= '0;
                rd_pix <= rd_pix + PIX_W'(1);
              end else begin
                rd_ch <= rd_ch + CH_W'(1);
              end
            end
          end
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

endmodule
